// File: rtl/lbdr_route_ctrl.sv
// LBDR route computation for one router input port: routes a packet's header and holds the port until its tail.
// Optional build macro LBDR_DEROUTE_EN adds cfg_dr and sends unroutable headers to that fallback port.
module lbdr_route_ctrl #(
    parameter int unsigned      ADDR_W  = 4,
    parameter int unsigned      FID_W   = 3,
    parameter logic [FID_W-1:0] HDR_ID  = 3'b001,
    parameter logic [FID_W-1:0] BODY_ID = 3'b010,
    parameter logic [FID_W-1:0] TAIL_ID = 3'b100,
    parameter int unsigned      LEN_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [7:0]        cfg_rxy,
    input  logic [3:0]        cfg_cx,
    input  logic [ADDR_W-1:0] cfg_cur_addr,
`ifdef LBDR_DEROUTE_EN
    input  logic [1:0]        cfg_dr,
`endif
    input  logic              flit_valid,
    output logic              flit_ready,
    input  logic [FID_W-1:0]  flit_id,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              sa_stall,
    output logic [4:0]        port_req,
    output logic              pkt_active,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              err
);

    localparam int unsigned      HW      = ADDR_W / 2;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [4:0]         port_req_q, port_req_d;
    logic [LEN_W-1:0]   pkt_len_q, pkt_len_d;
    logic               err_q, err_d;

    logic [7:0]         rxy_q;
    logic [3:0]         cx_q;
    logic [ADDR_W-1:0]  cur_q;
`ifdef LBDR_DEROUTE_EN
    logic [1:0]         dr_q;
`endif

    // Config is frozen while a packet is in flight so the held route stays coherent.
    always_ff @(posedge clk) begin
        if (rst || (cfg_load && state_q == IDLE)) begin
            rxy_q <= cfg_rxy;
            cx_q  <= cfg_cx;
            cur_q <= cfg_cur_addr;
`ifdef LBDR_DEROUTE_EN
            dr_q  <= cfg_dr;
`endif
        end
    end

    logic [HW-1:0] x_cur, y_cur, x_dst, y_dst;
    logic          n1, s1, e1, w1;
    logic          rsw, rse, rws, rwn, res, ren, rnw, rne;
    logic          cs, cw, ce, cn;
    logic          rn, re, rw, rs, rl;
    logic [4:0]    route;

    assign x_cur = cur_q[HW-1:0];
    assign y_cur = cur_q[ADDR_W-1:HW];
    assign x_dst = dst_addr[HW-1:0];
    assign y_dst = dst_addr[ADDR_W-1:HW];

    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;

    assign {rsw, rse, rws, rwn, res, ren, rnw, rne} = rxy_q;
    assign {cs, cw, ce, cn} = cx_q;

    assign rn = ((n1 & ~e1 & ~w1) | (n1 & e1 & rne) | (n1 & w1 & rnw)) & cn;
    assign re = ((e1 & ~n1 & ~s1) | (e1 & n1 & ren) | (e1 & s1 & res)) & ce;
    assign rw = ((w1 & ~n1 & ~s1) | (w1 & n1 & rwn) | (w1 & s1 & rws)) & cw;
    assign rs = ((s1 & ~e1 & ~w1) | (s1 & e1 & rse) | (s1 & w1 & rsw)) & cs;
    assign rl = ~n1 & ~e1 & ~w1 & ~s1;

    // One-hot {L,S,W,E,N}; an all-zero result means the header is unroutable.
    always_comb begin
        route = '0;
        if (rl)      route[4] = 1'b1;
        else if (rn) route[0] = 1'b1;
        else if (re) route[1] = 1'b1;
        else if (rw) route[2] = 1'b1;
        else if (rs) route[3] = 1'b1;
`ifdef LBDR_DEROUTE_EN
        else begin
            case (dr_q)
                2'b00:   route[0] = cn;
                2'b01:   route[1] = ce;
                2'b10:   route[2] = cw;
                default: route[3] = cs;
            endcase
        end
`endif
    end

    logic accept, is_hdr, is_body, is_tail, unroutable;

    assign accept     = flit_valid & ~sa_stall;
    assign is_hdr     = flit_id == HDR_ID;
    assign is_body    = flit_id == BODY_ID;
    assign is_tail    = flit_id == TAIL_ID;
    assign unroutable = route == 5'b00000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            port_req_q <= '0;
            pkt_len_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_req_q <= port_req_d;
            pkt_len_q  <= pkt_len_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (is_hdr)
                state_d = unroutable ? IDLE : ACTIVE;
            else if (is_tail && state_q == ACTIVE)
                state_d = IDLE;
        end
    end

    always_comb begin
        port_req_d = port_req_q;
        pkt_len_d  = pkt_len_q;
        err_d      = 1'b0;
        if (accept) begin
            if (is_hdr) begin
                port_req_d = route;
                pkt_len_d  = unroutable ? '0 : LEN_ONE;
                err_d      = unroutable | (state_q == ACTIVE);
            end else if (is_body) begin
                if (state_q == ACTIVE) begin
                    if (pkt_len_q != LEN_MAX)
                        pkt_len_d = pkt_len_q + LEN_ONE;
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_tail) begin
                if (state_q == ACTIVE) begin
                    port_req_d = '0;
                    pkt_len_d  = '0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign flit_ready = ~sa_stall;
    assign port_req   = port_req_q;
    assign pkt_active = state_q == ACTIVE;
    assign pkt_len    = pkt_len_q;
    assign err        = err_q;

endmodule
